// File: rtl/unpacker_arb.sv
// Two-requester packet arbiter in front of unpacker_fsm: grants whole packets
// round-robin, muxes the owner's word stream, counts packets and flags protocol errors.
module unpacker_arb #(
  parameter int IN_IFC_SZ_B = 160
) (
  input  logic                       clk,
  input  logic                       reset_L,
  input  logic                       a_val,
  input  logic                       a_sop,
  input  logic                       a_eop,
  input  logic [7:0]                 a_vbc,
  input  logic [IN_IFC_SZ_B*8-1:0]   a_data,
  output logic                       a_ready,
  input  logic                       b_val,
  input  logic                       b_sop,
  input  logic                       b_eop,
  input  logic [7:0]                 b_vbc,
  input  logic [IN_IFC_SZ_B*8-1:0]   b_data,
  output logic                       b_ready,
  output logic                       val,
  output logic                       sop,
  output logic                       eop,
  output logic [7:0]                 vbc,
  output logic [IN_IFC_SZ_B*8-1:0]   data,
  input  logic                       ready,
  output logic [1:0]                 grant,
  output logic [15:0]                pkt_cnt_a,
  output logic [15:0]                pkt_cnt_b,
  output logic                       proto_err
);

  localparam logic [8:0] LP_MAX_VBC = 9'(IN_IFC_SZ_B);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic         r_lastB;
  logic         r_first;
  logic [15:0]  r_cntA;
  logic [15:0]  r_cntB;
  logic         r_err;
  logic         w_reqA;
  logic         w_reqB;
  logic         w_xfer;
  logic         w_vbcBad;

  assign w_reqA   = a_val && a_sop;
  assign w_reqB   = b_val && b_sop;
  assign w_xfer   = val && ready;
  assign w_vbcBad = (vbc == 8'd0) || ({1'b0, vbc} > LP_MAX_VBC);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Both requesting: the side not granted last wins; r_lastB=1 after reset gives A priority.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_reqA && (!w_reqB || r_lastB)) w_next = OWN_A;
        else if (w_reqB)                    w_next = OWN_B;
      end
      OWN_A, OWN_B: begin
        if (w_xfer && eop) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    grant   = 2'b00;
    val     = 1'b0;
    sop     = 1'b0;
    eop     = 1'b0;
    vbc     = 8'd0;
    data    = '0;
    a_ready = 1'b0;
    b_ready = 1'b0;
    case (r_state)
      OWN_A: begin
        grant   = 2'b01;
        val     = a_val;
        sop     = a_sop;
        eop     = a_eop;
        vbc     = a_vbc;
        data    = a_data;
        a_ready = ready;
      end
      OWN_B: begin
        grant   = 2'b10;
        val     = b_val;
        sop     = b_sop;
        eop     = b_eop;
        vbc     = b_vbc;
        data    = b_data;
        b_ready = ready;
      end
      default: ;
    endcase
  end

  // r_first marks that the owner's next transfer is the opening word of its packet.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_lastB <= 1'b1;
      r_first <= 1'b0;
    end else begin
      if (r_state == IDLE && w_next == OWN_A) r_lastB <= 1'b0;
      if (r_state == IDLE && w_next == OWN_B) r_lastB <= 1'b1;
      if (r_state == IDLE) r_first <= 1'b1;
      else if (w_xfer)     r_first <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_cntA <= 16'd0;
      r_cntB <= 16'd0;
      r_err  <= 1'b0;
    end else begin
      if (w_xfer && eop && r_state == OWN_A && r_cntA != 16'hFFFF) r_cntA <= r_cntA + 16'd1;
      if (w_xfer && eop && r_state == OWN_B && r_cntB != 16'hFFFF) r_cntB <= r_cntB + 16'd1;
      if (w_xfer && ((sop && !r_first) || w_vbcBad)) r_err <= 1'b1;
    end
  end

  assign pkt_cnt_a = r_cntA;
  assign pkt_cnt_b = r_cntB;
  assign proto_err = r_err;

endmodule
